// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ write-domain producers.
// Handshake: a beat moves on a cycle where req_valid[i] & req_ready[i]; that same cycle raises wr_rq.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8,
    localparam int CW       = $clog2(MAX_BURST) + 1,
    localparam int IW       = $clog2(NREQ)
) (
    input  logic                  w_clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  full,
    output logic                  wr_rq,
    output logic [WIDTH-1:0]      wdata,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [CW-1:0]         burst_cnt
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_last_owner;
    logic [NREQ-1:0] r_grant;
    logic [CW-1:0]   r_burst_cnt;

    logic            w_any;
    logic            w_hi_found;
    logic [IW-1:0]   w_hi_sel;
    logic [IW-1:0]   w_lo_sel;
    logic [IW-1:0]   w_sel;
    logic            w_xfer;
    logic            w_end;
    logic [WIDTH-1:0] w_wdata;

    // Rotating priority: lowest valid index above last_owner wins, else wrap to the lowest valid index.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_sel   = '0;
        w_lo_sel   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IW'(i) > r_last_owner) begin
                    w_hi_found = 1'b1;
                    w_hi_sel   = IW'(i);
                end else begin
                    w_lo_sel = IW'(i);
                end
            end
        end
        w_sel = w_hi_found ? w_hi_sel : w_lo_sel;
    end

    assign w_any  = |req_valid;
    assign w_xfer = (r_state == S_BURST) & req_valid[r_owner] & ~full;
    assign w_end  = w_xfer & (req_last[r_owner] | (r_burst_cnt == CW'(MAX_BURST - 1)));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_BURST;
            S_BURST: if (w_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= '0;
            r_last_owner <= IW'(NREQ - 1);
            r_grant      <= '0;
            r_burst_cnt  <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_any) begin
                r_owner     <= w_sel;
                r_grant     <= NREQ'(1) << w_sel;
                r_burst_cnt <= '0;
            end
        end else if (w_end) begin
            r_grant      <= '0;
            r_burst_cnt  <= '0;
            r_last_owner <= r_owner;
        end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end

    // Owner data is forwarded whether or not it is valid; zero outside a burst.
    always_comb begin
        w_wdata = '0;
        if (r_state == S_BURST) begin
            for (int i = 0; i < NREQ; i++) begin
                if (r_owner == IW'(i)) w_wdata = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign busy      = (r_state == S_BURST);
    assign req_ready = (busy && !full) ? r_grant : '0;
    assign wr_rq     = w_xfer;
    assign wdata     = w_wdata;
    assign grant     = r_grant;
    assign burst_cnt = r_burst_cnt;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the async FIFO among NREQ producers in the write clock domain.
- Grants one requester at a time for a burst, which ends on req_last or at MAX_BURST beats.
- Forwards that requester's data and write strobe to the FIFO write port and back-pressures it with the FIFO's registered full flag.

Parameters:
- WIDTH, 8, data word width (matches FIFO WIDTH)
- NREQ, 4, number of requesters (2..16)
- MAX_BURST, 8, maximum beats per grant before forced re-arbitration (>=1)

Ports:
- w_clk  input  1  write-domain clock
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  NREQ  per-requester data valid
- req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- req_last  input  NREQ  per-requester end-of-burst marker, qualified by valid
- req_ready  output  NREQ  per-requester accept; transfer = valid & ready
- full  input  1  registered full flag from FIFO write side
- wr_rq  output  1  FIFO write request
- wdata  output  WIDTH  FIFO write data
- grant  output  NREQ  one-hot current owner, all-zero in IDLE
- busy  output  1  high in BURST state
- burst_cnt  output  $clog2(MAX_BURST)+1  beats accepted in the current burst

Behaviour:
- Reset values: state=IDLE, grant=0, busy=0, burst_cnt=0, last_owner=NREQ-1, so requester 0 has top priority first. wr_rq, req_ready and wdata are combinational and evaluate to 0.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid is high, select the first valid index searching from last_owner+1 upward, modulo NREQ.
  - Register the selection as one-hot grant and go to BURST.
  - The selection consumes one cycle; no data moves in IDLE.
  - If no req_valid is high, stay in IDLE.
- BURST:
  - req_ready[owner] = ~full; all other req_ready bits = 0.
  - wr_rq = req_valid[owner] & ~full.
  - wdata = req_data[owner slice], driven regardless of valid.
  - Each transfer increments burst_cnt.
- Burst end: a transfer with req_last[owner]=1, or with burst_cnt==MAX_BURST-1, ends the burst. Next cycle: state=IDLE, grant=0, burst_cnt=0, last_owner=owner.
- Back-to-back bursts: minimum one idle cycle between bursts (arbitration bubble). Maximum sustained throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Owner drops valid mid-burst: grant is held (lock), no timeout. Other requesters wait.
- full high: no transfer, burst_cnt holds, grant holds, wr_rq=0. full rising in the same cycle as a beat blocks that beat.
- Non-owner valid/last inputs are ignored and never alter state.
- req_last on a non-transfer cycle (full=1) has no effect until the beat is actually accepted.
- MAX_BURST=1: every beat ends the burst; arbitration alternates fairly beat by beat.
- Wrap-around: priority search wraps from NREQ-1 to 0. A sole active requester is re-granted after each bubble.
- Reset mid-burst: immediate return to reset values. A beat in flight that cycle is not written (wr_rq=0 during reset).
- No combinational path from full to grant or state other than through the registered FSM; wr_rq/req_ready depend combinationally on full and req_valid[owner].

Test Plan:
- Reset, then req_valid=4'b0101 held, req_last=1 on every beat, full=0 -> grants alternate 0,2,0,2 with one bubble cycle each; each wdata matches the owner's data; wr_rq high one cycle per grant.
- Requester 1 only, 20 beats, req_last never set, MAX_BURST=8 -> bursts of 8,8,4 beats with burst_cnt 0..7; 1 idle cycle between bursts; 20 writes total.
- Owner 3 mid-burst, full asserted for 5 cycles -> wr_rq=0 and req_ready=0 for those 5 cycles; burst_cnt frozen; resumes with no lost or duplicated data.
- Owner 2 drops valid for 3 cycles while 0 and 1 are valid -> grant stays 4'b0100; burst continues when valid returns; next grant goes to 3 if valid, else wraps to 0.
- All four valid, last=1 on every beat, 40 beats -> each requester gets exactly 10 beats in order 0,1,2,3,...; no starvation.
- Assert rst_n=0 during the 3rd beat of a burst -> grant=0, busy=0, burst_cnt=0 immediately; after release, requester 0 has first priority.
